// File: rtl/rv32_data_mem_ctrl_if.sv
// rtl/rv32_data_mem_ctrl_if.sv - LSU-to-data-memory request/response bundle
//
// Purpose: groups the load/store request channel, the response strobe and
// the clear status into one bundle shared by the LSU and the memory block.
// Ports (signals):
//   req_valid, req_ready            request handshake
//   req_we, req_size, req_unsigned  access kind (store, size code, zero-extend)
//   req_addr, req_wdata             byte address, right-aligned store data
//   rsp_valid, rsp_rdata, rsp_err   one-cycle response strobe with result
//   clear_busy                      clear sweep in progress
// Modports: master = LSU side, slave = memory side.

interface rv32_data_mem_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        clear_busy;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, clear_busy
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, clear_busy
    );
endinterface

// File: rtl/rv32_data_mem_ctrl.sv
// rtl/rv32_data_mem_ctrl.sv - byte-addressable RV32 data memory with sized loads/stores
//
// Purpose: DEPTH_WORDS x 32 data array serving LB/LH/LW/LBU/LHU/SB/SH/SW
// with a fixed WAIT_STATES response latency and an optional zeroing sweep
// after reset. Misaligned, illegal-size and out-of-range accesses respond
// with rsp_err=1 and never touch the array.
// Ports:
//   clk  in  clock, rising edge
//   rst  in  synchronous active-high reset
//   bus  slave modport of rv32_data_mem_ctrl_if (request, response, clear_busy)

module rv32_data_mem_ctrl #(
    parameter int DEPTH_WORDS    = 1024,
    parameter int WAIT_STATES    = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    rv32_data_mem_ctrl_if.slave   bus
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_WAIT, S_RESP} state_e;

    localparam state_e     RESET_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
    localparam logic [2:0] WAIT_LAST   = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    state_e          state_q, state_d;
    logic [AW-1:0]   clr_idx_q, clr_idx_d;
    logic [2:0]      wait_cnt_q, wait_cnt_d;

    logic            lat_we_q;
    logic [1:0]      lat_size_q;
    logic            lat_uns_q;
    logic [31:0]     lat_addr_q;
    logic [31:0]     lat_wdata_q;

    logic            rsp_valid_q;
    logic [31:0]     rsp_rdata_q;
    logic            rsp_err_q;

    logic [31:0]     mem_q [DEPTH_WORDS];

    // With zero wait states the commit edge is also the accept edge, so the
    // operation is taken straight from the bus while IDLE.
    logic            op_we, op_uns;
    logic [1:0]      op_size, op_off;
    logic [31:0]     op_addr, op_wdata;
    logic [AW-1:0]   op_idx;
    logic            op_err;
    logic [3:0]      op_be;
    logic [31:0]     op_wlanes;
    logic [31:0]     rd_word;
    logic [7:0]      rd_byte;
    logic [15:0]     rd_half;
    logic [31:0]     load_val;
    logic            accept;
    logic            commit;

    assign accept   = (state_q == S_IDLE) && bus.req_valid;
    assign commit   = (state_d == S_RESP);

    assign op_we    = (state_q == S_IDLE) ? bus.req_we       : lat_we_q;
    assign op_size  = (state_q == S_IDLE) ? bus.req_size     : lat_size_q;
    assign op_uns   = (state_q == S_IDLE) ? bus.req_unsigned : lat_uns_q;
    assign op_addr  = (state_q == S_IDLE) ? bus.req_addr     : lat_addr_q;
    assign op_wdata = (state_q == S_IDLE) ? bus.req_wdata    : lat_wdata_q;

    assign op_idx   = op_addr[AW+1:2];
    assign op_off   = op_addr[1:0];
    assign op_err   = (op_size == 2'b11)
                   || (op_size == 2'b01 && op_off[0])
                   || (op_size == 2'b10 && op_off != 2'b00)
                   || (|op_addr[31:AW+2]);

    // Replicating the store data across lanes lets the byte enables alone
    // pick the destination lane.
    always_comb begin
        op_be     = 4'b1111;
        op_wlanes = op_wdata;
        case (op_size)
            2'b00: begin
                op_be     = 4'b0001 << op_off;
                op_wlanes = {4{op_wdata[7:0]}};
            end
            2'b01: begin
                op_be     = 4'b0011 << {op_off[1], 1'b0};
                op_wlanes = {2{op_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign rd_word = mem_q[op_idx];
    assign rd_byte = rd_word[{op_off, 3'b000} +: 8];
    assign rd_half = rd_word[{op_off[1], 4'b0000} +: 16];

    always_comb begin
        load_val = rd_word;
        case (op_size)
            2'b00:   load_val = op_uns ? {24'd0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            2'b01:   load_val = op_uns ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        clr_idx_d  = clr_idx_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            S_CLEAR: begin
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == AW'(DEPTH_WORDS - 1)) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (bus.req_valid) begin
                    wait_cnt_d = 3'd0;
                    state_d    = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    state_d = S_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 3'd1;
                end
            end
            S_RESP: state_d = S_IDLE;
            default: state_d = RESET_STATE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RESET_STATE;
            clr_idx_q   <= '0;
            wait_cnt_q  <= 3'd0;
            lat_we_q    <= 1'b0;
            lat_size_q  <= 2'b00;
            lat_uns_q   <= 1'b0;
            lat_addr_q  <= 32'd0;
            lat_wdata_q <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_idx_q  <= clr_idx_d;
            wait_cnt_q <= wait_cnt_d;
            if (accept) begin
                lat_we_q    <= bus.req_we;
                lat_size_q  <= bus.req_size;
                lat_uns_q   <= bus.req_unsigned;
                lat_addr_q  <= bus.req_addr;
                lat_wdata_q <= bus.req_wdata;
            end
            rsp_valid_q <= commit;
            rsp_err_q   <= commit && op_err;
            rsp_rdata_q <= (commit && !op_err && !op_we) ? load_val : 32'd0;
        end
    end

    // Array has no reset; reset only suppresses writes so an in-flight store
    // is dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == S_CLEAR) begin
                mem_q[clr_idx_q] <= 32'd0;
            end else if (commit && op_we && !op_err) begin
                for (int b = 0; b < 4; b++) begin
                    if (op_be[b]) begin
                        mem_q[op_idx][8*b +: 8] <= op_wlanes[8*b +: 8];
                    end
                end
            end
        end
    end

    assign bus.req_ready  = (state_q == S_IDLE) && !rst;
    assign bus.clear_busy = (state_q == S_CLEAR) && !rst;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_rdata  = rsp_rdata_q;
    assign bus.rsp_err    = rsp_err_q;
endmodule

// File: tb/tb_rv32_data_mem_ctrl.sv
// tb/tb_rv32_data_mem_ctrl.sv - self-checking bench for rv32_data_mem_ctrl

module tb_rv32_data_mem_ctrl;
    localparam int DEPTH  = 16;
    localparam int WS     = 3;
    localparam int NBYTES = DEPTH * 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rv32_data_mem_ctrl_if bus();

    rv32_data_mem_ctrl #(
        .DEPTH_WORDS   (DEPTH),
        .WAIT_STATES   (WS),
        .CLEAR_ON_RESET(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int vectors    = 0;
    int miscompares = 0;

    logic rst_at_edge = 1'b0;
    always @(posedge clk) rst_at_edge <= rst;

    // Behavioural model: byte-array memory, one outstanding request.
    logic [7:0]  mem8 [NBYTES];
    int          clr_left = 0;
    bit          pending  = 0;
    int          due      = 0;
    int          ncyc     = 0;
    logic [31:0] pend_rdata = 32'd0;
    logic        pend_err   = 1'b0;

    function automatic void model_access(input logic we, input logic [1:0] size, input logic uns,
                                         input logic [31:0] addr, input logic [31:0] wdata,
                                         output logic [31:0] rdata, output logic err);
        int n;
        n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        err = (size == 2'd3) || ((addr % n) != 0) || (addr >= 32'(NBYTES));
        rdata = 32'd0;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < n; i++) mem8[addr + 32'(i)] = wdata[8*i +: 8];
            end else begin
                for (int i = 0; i < n; i++) rdata = rdata | (32'(mem8[addr + 32'(i)]) << (8*i));
                if (!uns && n < 4 && rdata[8*n-1]) rdata = rdata | ~((32'd1 << (8*n)) - 32'd1);
            end
        end
    endfunction

    task automatic monitor_loop();
        logic        exp_busy, exp_ready, exp_valid, exp_err;
        logic [31:0] exp_rdata;
        logic [35:0] act, expv;
        forever begin
            @(negedge clk);
            if (rst && !rst_at_edge) continue;
            if (rst_at_edge) begin
                clr_left = DEPTH;
                pending  = 0;
                for (int i = 0; i < NBYTES; i++) mem8[i] = 8'd0;
            end
            exp_busy  = !rst && clr_left > 0;
            exp_ready = !rst && clr_left == 0 && !pending;
            exp_valid = pending && ncyc == due;
            exp_err   = exp_valid && pend_err;
            exp_rdata = exp_valid ? pend_rdata : 32'd0;
            act  = {bus.clear_busy, bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata};
            expv = {exp_busy, exp_ready, exp_valid, exp_err, exp_rdata};
            vectors++;
            if (act !== expv) begin
                miscompares++;
                $display("FAIL cycle%0d busy/ready/valid/err/rdata actual %b/%b/%b/%b/%h expected %b/%b/%b/%b/%h",
                         ncyc, act[35], act[34], act[33], act[32], act[31:0],
                         expv[35], expv[34], expv[33], expv[32], expv[31:0]);
            end
            if (exp_valid) pending = 0;
            if (!rst && clr_left > 0) clr_left--;
            if (exp_ready && bus.req_valid) begin
                model_access(bus.req_we, bus.req_size, bus.req_unsigned, bus.req_addr,
                             bus.req_wdata, pend_rdata, pend_err);
                pending = 1;
                due     = ncyc + WS + 1;
            end
            ncyc++;
        end
    endtask

    task automatic check_lit(input string name, input logic [32:0] act, input logic [32:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual err=%b data=%h expected err=%b data=%h",
                     name, act[32], act[31:0], exp[32], exp[31:0]);
        end
    endtask

    task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, output bit ok);
        @(posedge clk); #1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        bus.req_valid    = 1'b1;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.req_ready) begin ok = 1; break; end
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: actual no req_ready expected req_ready within 100 cycles");
        end
    endtask

    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [32:0] res, output int lat);
        bit ok;
        res = 33'd0;
        lat = -1;
        drive(we, size, uns, addr, wdata, ok);
        if (!ok) return;
        ok  = 0;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (bus.rsp_valid) begin
                res = {bus.rsp_err, bus.rsp_rdata};
                ok  = 1;
                break;
            end
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL rsp_timeout: actual no rsp_valid expected rsp_valid within 20 cycles");
        end
    endtask

    task automatic req(input string name, input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [32:0] exp);
        logic [32:0] res;
        int          lat;
        do_req(we, size, uns, addr, wdata, res, lat);
        check_lit(name, res, exp);
    endtask

    task automatic wait_clear(output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.clear_busy) n++;
            else if (n > 0) break;
        end
    endtask

    task automatic main_seq();
        int          n, lat;
        bit          ok;
        logic [32:0] res;

        // 1: clear sweep then every word reads zero
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        wait_clear(n);
        check_lit("clear_cycles", 33'(n), 33'd16);
        for (int w = 0; w < DEPTH; w++)
            req($sformatf("clr_lw%0d", w), 1'b0, 2'd2, 1'b0, 32'(w * 4), 32'd0, 33'd0);

        // 2: word store then signed/unsigned byte loads
        req("sw_8",  1'b1, 2'd2, 1'b0, 32'h8, 32'h8000_00F1, 33'd0);
        req("lb_8",  1'b0, 2'd0, 1'b0, 32'h8, 32'd0, {1'b0, 32'hFFFF_FFF1});
        req("lbu_8", 1'b0, 2'd0, 1'b1, 32'h8, 32'd0, {1'b0, 32'h0000_00F1});
        req("lw_8",  1'b0, 2'd2, 1'b0, 32'h8, 32'd0, {1'b0, 32'h8000_00F1});

        // 3: half store in upper lanes, byte store in lane 3
        req("sh_a",   1'b1, 2'd1, 1'b0, 32'hA, 32'h0000_BEEF, 33'd0);
        req("lw_8b",  1'b0, 2'd2, 1'b0, 32'h8, 32'd0, {1'b0, 32'hBEEF_00F1});
        req("lh_a",   1'b0, 2'd1, 1'b0, 32'hA, 32'd0, {1'b0, 32'hFFFF_BEEF});
        req("lhu_a",  1'b0, 2'd1, 1'b1, 32'hA, 32'd0, {1'b0, 32'h0000_BEEF});
        req("sb_b",   1'b1, 2'd0, 1'b0, 32'hB, 32'hFFFF_FF7F, 33'd0);
        req("lw_8c",  1'b0, 2'd2, 1'b0, 32'h8, 32'd0, {1'b0, 32'h7FEF_00F1});
        req("lb_b",   1'b0, 2'd0, 1'b0, 32'hB, 32'd0, {1'b0, 32'h0000_007F});

        // 4: latency with three wait states, last word of the array
        do_req(1'b1, 2'd2, 1'b0, 32'h3C, 32'hA5A5_5A5A, res, lat);
        check_lit("latency", 33'(lat), 33'd4);
        req("lw_3c", 1'b0, 2'd2, 1'b0, 32'h3C, 32'd0, {1'b0, 32'hA5A5_5A5A});

        // 5: rejected accesses leave the word intact
        req("sw_4",     1'b1, 2'd2, 1'b0, 32'h4,  32'hCAFE_F00D, 33'd0);
        req("lw_6",     1'b0, 2'd2, 1'b0, 32'h6,  32'd0,         {1'b1, 32'd0});
        req("sh_3",     1'b1, 2'd1, 1'b0, 32'h3,  32'hFFFF_FFFF, {1'b1, 32'd0});
        req("size3_4",  1'b1, 2'd3, 1'b0, 32'h4,  32'h1111_1111, {1'b1, 32'd0});
        req("lw_40",    1'b0, 2'd2, 1'b0, 32'h40, 32'd0,         {1'b1, 32'd0});
        req("sw_44",    1'b1, 2'd2, 1'b0, 32'h44, 32'h2222_2222, {1'b1, 32'd0});
        req("lw_4",     1'b0, 2'd2, 1'b0, 32'h4,  32'd0,         {1'b0, 32'hCAFE_F00D});

        // 6: reset during WAIT drops the store and restarts the sweep
        drive(1'b1, 2'd2, 1'b0, 32'h0, 32'h1234_5678, ok);
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        wait_clear(n);
        check_lit("clear_cycles_rst", 33'(n), 33'd16);
        req("lw_0_after_rst", 1'b0, 2'd2, 1'b0, 32'h0, 32'd0, 33'd0);
        req("lw_4_after_rst", 1'b0, 2'd2, 1'b0, 32'h4, 32'd0, 33'd0);

        repeat (4) @(posedge clk);
    endtask

    initial begin
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'd0;
        bus.req_wdata    = 32'd0;
        fork
            monitor_loop();
            main_seq();
        join_any
        disable fork;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
